// File: rtl/bcd2bin_seq.sv
`default_nettype none
// ============================================================================
// Module  : bcd2bin_seq
// Brief   : Sequential packed-BCD to binary converter (reverse double-dabble,
//           one shift/correct iteration per clock) with range/validity flag.
// Revision: 1.0 - initial release
// ============================================================================
module bcd2bin_seq #(
    parameter int BIN_WIDTH = 8,
    parameter int BCD_CNT   = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [BCD_CNT*4-1:0]   bcd_in,
    output logic                   busy,
    output logic                   done,
    output logic [BIN_WIDTH-1:0]   bin_out,
    output logic                   err
);

    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam int BCD_W = BCD_CNT * 4;
    localparam int WRK_W = BCD_W + BIN_WIDTH;

    localparam logic [0:0]       c_IDLE = 1'b0;
    localparam logic [0:0]       c_RUN  = 1'b1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(BIN_WIDTH - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    logic [0:0]       r_state;
    logic [WRK_W-1:0] r_work;
    logic [CNT_W-1:0] r_cnt;
    logic             r_inv;
    logic             r_busy;
    logic             r_done;
    logic [BIN_WIDTH-1:0] r_bin;
    logic             r_err;

    logic [WRK_W-1:0]   w_shifted;
    logic [WRK_W-1:0]   w_next;
    logic [BCD_CNT-1:0] w_nib_bad;
    logic               w_inv;
    logic               w_ovf;
    logic               w_err;

    assign w_shifted = r_work >> 1;
    assign w_next[BIN_WIDTH-1:0] = w_shifted[BIN_WIDTH-1:0];

    // Each BCD nibble is corrected independently after the shift.
    for (genvar i = 0; i < BCD_CNT; i++) begin : g_nib
        logic [3:0] w_nib;
        assign w_nib = w_shifted[BIN_WIDTH + 4*i +: 4];
        assign w_next[BIN_WIDTH + 4*i +: 4] = (w_nib >= 4'd8) ? (w_nib - 4'd3) : w_nib;
        assign w_nib_bad[i] = (bcd_in[4*i +: 4] > 4'd9);
    end

    assign w_inv = |w_nib_bad;
    assign w_ovf = |w_next[WRK_W-1:BIN_WIDTH];
    assign w_err = r_inv | w_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_work  <= '0;
            r_cnt   <= '0;
            r_inv   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bin   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_work  <= {bcd_in, {BIN_WIDTH{1'b0}}};
                        r_cnt   <= '0;
                        r_inv   <= w_inv;
                        r_busy  <= 1'b1;
                        r_state <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_work <= w_next;
                    r_cnt  <= r_cnt + c_ONE;
                    // Invalid digits still run the full iteration count; only the result is squashed.
                    if (r_cnt == c_LAST) begin
                        r_err   <= w_err;
                        r_bin   <= w_err ? '0 : w_next[BIN_WIDTH-1:0];
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign bin_out = r_bin;
    assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd2bin_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_bcd2bin_seq
// Brief   : Self-checking bench for bcd2bin_seq (directed vectors + sequences).
// Revision: 1.0 - initial release
// ============================================================================
module tb_bcd2bin_seq;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic [11:0] bcd_in = '0;
    logic        busy;
    logic        done;
    logic [7:0]  bin_out;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [11:0] bcd;
        int          bin;
        int          err;
    } vec_t;

    vec_t vecs[10];

    bcd2bin_seq #(.BIN_WIDTH(8), .BCD_CNT(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .err     (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one conversion from idle and checks latency, busy width and results.
    task automatic run_conv(input logic [11:0] b, input int eb, input int ee, input string name);
        int lat = 0;
        int bsy = 0;
        start  = 1'b1;
        bcd_in = b;
        tick();
        start  = 1'b0;
        bcd_in = ~b;
        for (int i = 1; i <= 20; i++) begin
            if (busy) bsy++;
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
        check({name, " latency"}, lat, 8);
        check({name, " busy_cycles"}, bsy, 8);
        check({name, " bin_out"}, int'(bin_out), eb);
        check({name, " err"}, int'(err), ee);
        check({name, " busy_at_done"}, int'(busy), 0);
        tick();
        check({name, " done_pulse"}, int'(done), 0);
    endtask

    initial begin
        int k;
        int ndone;
        logic [11:0] b;

        vecs[0] = '{12'h255, 255, 0};
        vecs[1] = '{12'h000,   0, 0};
        vecs[2] = '{12'h009,   9, 0};
        vecs[3] = '{12'h100, 100, 0};
        vecs[4] = '{12'h256,   0, 1};
        vecs[5] = '{12'h999,   0, 1};
        vecs[6] = '{12'h1A3,   0, 1};
        vecs[7] = '{12'h123, 123, 0};
        vecs[8] = '{12'h0F0,   0, 1};
        vecs[9] = '{12'h099,  99, 0};

        #12;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset bin_out", int'(bin_out), 0);
        check("reset err", int'(err), 0);
        tick();
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            run_conv(vecs[i].bcd, vecs[i].bin, vecs[i].err, $sformatf("vec%0d", i));
        end

        for (int v = 0; v <= 255; v++) begin
            b = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            run_conv(b, v, 0, $sformatf("sweep%0d", v));
        end

        // A start during RUN is ignored; a start in the done cycle is accepted.
        start  = 1'b1;
        bcd_in = 12'h050;
        tick();
        start  = 1'b0;
        tick();
        tick();
        tick();
        start  = 1'b1;
        bcd_in = 12'h200;
        tick();
        start  = 1'b0;
        bcd_in = 12'h000;
        k = 0;
        for (int i = 5; i <= 25; i++) begin
            tick();
            if (done) begin
                k = i;
                break;
            end
        end
        check("overlap latency", k, 8);
        check("overlap bin_out", int'(bin_out), 50);
        check("overlap err", int'(err), 0);
        run_conv(12'h200, 200, 0, "b2b");

        // Asynchronous reset in the middle of a conversion.
        start  = 1'b1;
        bcd_in = 12'h255;
        tick();
        start  = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midreset busy", int'(busy), 0);
        check("midreset done", int'(done), 0);
        check("midreset bin_out", int'(bin_out), 0);
        check("midreset err", int'(err), 0);
        tick();
        tick();
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) ndone++;
        end
        check("midreset no_done", ndone, 0);
        run_conv(12'h128, 128, 0, "postreset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
